// File: rtl/regs_file_mp.sv
// regs_file_mp: multi-port integer register file with write-back scoreboard and reset scrub.
//
// After a synchronous reset the block walks every entry writing zero (SCRUB), then enters RUN
// and raises ready_o. In RUN two writeback ports (0 = ALU, 1 = LSU) commit on the rising edge,
// NREAD combinational read ports return data and a per-entry busy flag, and issue_i marks a
// destination register as pending until a write to it commits.
//
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   we0_i/waddr0_i/wdata0_i     write port 0 (ALU)
//   we1_i/waddr1_i/wdata1_i     write port 1 (LSU), wins address collisions with port 0
//   issue_i/issue_addr_i        sets the busy bit of the issued destination
//   raddr_i                     packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata_o                     packed read data, port k at [k*DATA_W +: DATA_W]
//   busy_o                      per-read-port pending-write flag
//   ready_o                     scrub complete, writes and issues accepted
module regs_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we0_i,
  input  logic [ADDR_W-1:0]       waddr0_i,
  input  logic [DATA_W-1:0]       wdata0_i,
  input  logic                    we1_i,
  input  logic [ADDR_W-1:0]       waddr1_i,
  input  logic [DATA_W-1:0]       wdata1_i,
  input  logic                    issue_i,
  input  logic [ADDR_W-1:0]       issue_addr_i,
  input  logic [NREAD*ADDR_W-1:0] raddr_i,
  output logic [NREAD*DATA_W-1:0] rdata_o,
  output logic [NREAD-1:0]        busy_o,
  output logic                    ready_o
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam bit          ZeroEn = (ZERO_REG != 0);

  typedef enum logic [0:0] {StScrub, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   scrub_cnt_q;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic                ready_q;
  logic [DATA_W-1:0]   regs_q [DEPTH];

  logic run;
  logic commit0, commit1, issue_ok;

  // Entry 0 is hardwired to zero when ZERO_REG is set: never written, never busy.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return !(ZeroEn && (a == '0));
  endfunction

  assign run      = (state_q == StRun);
  assign commit0  = run && we0_i && addr_ok(waddr0_i);
  assign commit1  = run && we1_i && addr_ok(waddr1_i);
  assign issue_ok = run && issue_i && addr_ok(issue_addr_i);
  assign ready_o  = ready_q;

  // Issue is applied last so it wins over a same-cycle clear to the same entry.
  always_comb begin
    busy_d = busy_q;
    if (commit0)  busy_d[waddr0_i]     = 1'b0;
    if (commit1)  busy_d[waddr1_i]     = 1'b0;
    if (issue_ok) busy_d[issue_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StScrub;
      scrub_cnt_q <= '0;
      busy_q      <= '0;
      ready_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StScrub: begin
          scrub_cnt_q <= scrub_cnt_q + 1'b1;
          if (scrub_cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun:   busy_q <= busy_d;
        default: state_q <= StScrub;
      endcase
    end
  end

  // Storage has no reset; the scrub walk is what initialises it. Port 1 is written last so it
  // wins a same-address collision.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == StScrub) begin
        regs_q[scrub_cnt_q] <= '0;
      end else begin
        if (commit0) regs_q[waddr0_i] <= wdata0_i;
        if (commit1) regs_q[waddr1_i] <= wdata1_i;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              bz;

    assign ra = raddr_i[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = regs_q[ra];
      bz = busy_q[ra];
      if (commit0 && (waddr0_i == ra)) begin
        rd = wdata0_i;
        bz = 1'b0;
      end
      if (commit1 && (waddr1_i == ra)) begin
        rd = wdata1_i;
        bz = 1'b0;
      end
      if (!run || !addr_ok(ra)) begin
        rd = '0;
        bz = 1'b0;
      end
    end

    assign rdata_o[k*DATA_W +: DATA_W] = rd;
    assign busy_o[k]                   = bz;
  end

endmodule

// File: doc/regs_file_mp.md
# regs_file_mp

Parametrised multi-port integer register file with a write-back scoreboard and a hardware reset-scrub sequencer. It is the next-generation register file for the milano core: the decode stage reads operands and busy status on `NREAD` ports, and two writeback sources (ALU and LSU) write in the same cycle. After reset, the block clears every register before it accepts traffic, so reset state never depends on X-initialised storage.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth `DEPTH = 2**ADDR_W`
- `NREAD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, when 1, entry 0 always reads 0 and is never written or marked busy
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  synchronous reset, active-high
- `we0_i`  in  1  write enable, port 0 (ALU)
- `waddr0_i`  in  ADDR_W  write address, port 0
- `wdata0_i`  in  DATA_W  write data, port 0
- `we1_i`  in  1  write enable, port 1 (LSU)
- `waddr1_i`  in  ADDR_W  write address, port 1
- `wdata1_i`  in  DATA_W  write data, port 1
- `issue_i`  in  1  instruction issued with a destination register; sets its busy bit
- `issue_addr_i`  in  ADDR_W  destination of the issued instruction
- `raddr_i`  in  NREAD*ADDR_W  read addresses; port k occupies bits `[k*ADDR_W +: ADDR_W]`
- `rdata_o`  out  NREAD*DATA_W  read data, packed the same way as `raddr_i`
- `busy_o`  out  NREAD  per-read-port pending-write flag
- `ready_o`  out  1  scrub complete; the block accepts writes and issues

## Operation
- FSM states are SCRUB and RUN. `rst_i` moves the FSM to SCRUB, sets `scrub_cnt` to 0, and clears all busy bits.
- SCRUB: each cycle, write 0 to `regs[scrub_cnt]`, then increment `scrub_cnt`. When `scrub_cnt == DEPTH-1`, the FSM moves to RUN on the next edge. During SCRUB:
  - `we0_i`, `we1_i` and `issue_i` are ignored.
  - `rdata_o` is all 0.
  - `busy_o` is all 0.
  - `ready_o` is 0.
- If `rst_i` is asserted during SCRUB, the scrub restarts from entry 0.
- RUN, writes: a write is committed on the edge when its enable is high and its address is not 0 (address 0 is excluded only when `ZERO_REG=1`). If both ports target the same address in the same cycle, port 1 wins.
- RUN, reads (combinational):
  - If the address is 0 and `ZERO_REG=1`, the result is 0.
  - Otherwise, a same-cycle write to that address is forwarded; port 1 data has priority over port 0.
  - Otherwise, the result is the stored value.
- Scoreboard: one busy bit per entry.
  - `issue_i` sets `busy[issue_addr_i]`.
  - A committed write on either port clears `busy[waddr]`.
  - If an issue and a write hit the same address in the same cycle, the issue wins and the bit ends set.
  - Entry 0 is never set when `ZERO_REG=1`.
- `busy_o[k]` equals `busy[raddr_k]`, except it reads 0 when a committed write to `raddr_k` occurs in the same cycle (forwarded clear). A same-cycle issue does not raise `busy_o`; issue takes effect from the next cycle.

## Timing
- Values at reset: `ready_o=0`, `busy_o=0`, `rdata_o=0`, FSM in SCRUB.
- `ready_o` rises exactly `DEPTH` cycles after the first edge where `rst_i` is low. For the default parameters, that is 32 cycles.
- Write latency: the stored value is visible to reads from the cycle after the write edge. Within the write cycle itself, the value is visible through forwarding.
- Read path is zero-latency combinational. No registered outputs other than `ready_o`, which is decoded from FSM state.
- Busy bit set/clear takes effect on the next edge; the only combinational term is the forwarded clear.

## Test plan
- Reset scrub:
  - Stimulus: preload entry 5 with `0xDEADBEEF`, assert `rst_i` for 1 cycle, then release it.
  - Required: `ready_o` stays 0 for 32 cycles, and a write to entry 5 attempted during scrub is dropped. After `ready_o`=1, reading entry 5 returns `0x00000000`.
- Reset mid-scrub:
  - Stimulus: assert `rst_i` again at scrub cycle 10.
  - Required: `ready_o` rises 32 cycles after the second release, not 22.
- Dual-write collision:
  - Stimulus: `we0` writes `0x11` and `we1` writes `0x22`, both to entry 7, in the same cycle.
  - Required: the read port shows `0x22` in that cycle through forwarding, and the stored value is `0x22` next cycle.
- Zero register:
  - Stimulus: write `0xFFFF` to entry 0 and issue to entry 0.
  - Required: `rdata_o` for address 0 is 0 and `busy_o` is 0.
- Scoreboard:
  - Stimulus: issue to entry 3, then 2 cycles later write `0xABCD` to entry 3 on port 1.
  - Required: `busy_o` reads 1 until the write cycle, reads 0 in the write cycle with `rdata_o=0xABCD`, and stays 0 afterwards. A simultaneous issue and write to entry 4 leaves `busy_o`=1 next cycle.
- Parametrisation:
  - Stimulus: `NREAD=3`, `ADDR_W=4`.
  - Required: scrub takes 16 cycles, and all 3 read ports return independent values from entries 1, 2 and 15.
